// File: rtl/gray_code_decoder_if.sv
// Bundles the Gray input, error clear and decoded status of gray_code_decoder.
interface gray_code_decoder_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] gray_in;
  logic             clr_err;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             dir_up;
  logic             dir_down;
  logic             err;
  logic [7:0]       err_cnt;

  modport master (
    output gray_in, clr_err,
    input  bin_out, bin_valid, dir_up, dir_down, err, err_cnt
  );

  modport slave (
    input  gray_in, clr_err,
    output bin_out, bin_valid, dir_up, dir_down, err, err_cnt
  );
endinterface

// File: rtl/gray_code_decoder.sv
// Synchronises a remote Gray count, converts it to binary and classifies each change.
// States: FILL = synchroniser filling after reset | TRACK = decoding every edge.
module gray_code_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              reset,
  gray_code_decoder_if.slave bus
);
  typedef enum logic {FILL, TRACK} state_t;
  localparam int CW = $clog2(SYNC_STAGES + 1);

  state_t                             state;
  logic [CW-1:0]                      fill_cnt;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]  sync_q;
  logic [WIDTH-1:0]                   prev_gray;
  logic [WIDTH-1:0]                   bin_q;
  logic                               valid_q;
  logic                               up_q;
  logic                               down_q;
  logic                               err_q;
  logic [7:0]                         err_cnt_q;

  logic [WIDTH-1:0] sync_gray;
  logic [WIDTH-1:0] sync_bin;
  logic [WIDTH-1:0] next_bin;
  logic             step;
  logic             jump;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  always_comb begin
    sync_gray = sync_q[SYNC_STAGES-1];
    sync_bin  = gray2bin(sync_gray);
    next_bin  = bin_q + WIDTH'(1);
    step      = ($countones(sync_gray ^ prev_gray) == 1);
    jump      = ($countones(sync_gray ^ prev_gray) > 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      fill_cnt  <= CW'(SYNC_STAGES);
      sync_q    <= '0;
      prev_gray <= '0;
      bin_q     <= '0;
      valid_q   <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.gray_in};
      up_q   <= 1'b0;
      down_q <= 1'b0;
      case (state)
        FILL: begin
          if (fill_cnt == '0) begin
            bin_q     <= sync_bin;
            prev_gray <= sync_gray;
            valid_q   <= 1'b1;
            state     <= TRACK;
          end else begin
            fill_cnt <= fill_cnt - CW'(1);
          end
        end
        TRACK: begin
          prev_gray <= sync_gray;
          bin_q     <= sync_bin;
          up_q      <= step && (sync_bin == next_bin);
          down_q    <= step && (sync_bin != next_bin);
        end
        default: state <= FILL;
      endcase
      // A same-cycle illegal jump takes priority over the clear.
      if (state == TRACK && jump) begin
        err_q <= 1'b1;
        if (bus.clr_err)               err_cnt_q <= 8'd1;
        else if (err_cnt_q != 8'hFF)   err_cnt_q <= err_cnt_q + 8'd1;
      end else if (bus.clr_err) begin
        err_q     <= 1'b0;
        err_cnt_q <= '0;
      end
    end
  end

  assign bus.bin_out   = bin_q;
  assign bus.bin_valid = valid_q;
  assign bus.dir_up    = up_q;
  assign bus.dir_down  = down_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_gray_code_decoder.sv
// Directed and random checks of gray_code_decoder against a queue-based reference model.
module tb_gray_code_decoder;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;
  int   up_seen = 0;
  int   down_seen = 0;

  gray_code_decoder_if #(.WIDTH(4)) bus ();

  gray_code_decoder #(.WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: samples wait in a queue for the synchroniser latency.
  int q[$];
  int m_bin, m_prev, m_valid, m_up, m_down, m_err, m_cnt;

  function automatic int g2b(input int g);
    for (int i = 0; i < 16; i++) if ((i ^ (i >> 1)) == g) return i;
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_bin = 0; m_prev = 0; m_valid = 0; m_up = 0; m_down = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    int s, nb, d, jmp, clr;
    clr = int'(bus.clr_err);
    jmp = 0;
    q.push_back(int'(bus.gray_in));
    m_up = 0;
    m_down = 0;
    if (q.size() > 2) begin
      s = q.pop_front();
      nb = g2b(s);
      if (m_valid == 0) begin
        m_valid = 1;
      end else begin
        d = $countones(s ^ m_prev);
        if (d == 1) begin
          if (nb == (m_bin + 1) % 16) m_up = 1;
          else m_down = 1;
        end
        if (d > 1) jmp = 1;
      end
      m_bin = nb;
      m_prev = s;
    end
    if (jmp) begin
      m_err = 1;
      m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    end else if (clr) begin
      m_err = 0;
      m_cnt = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("bin_out",   32'(bus.bin_out),   32'(m_bin));
    chk("bin_valid", 32'(bus.bin_valid), 32'(m_valid));
    chk("dir_up",    32'(bus.dir_up),    32'(m_up));
    chk("dir_down",  32'(bus.dir_down),  32'(m_down));
    chk("err",       32'(bus.err),       32'(m_err));
    chk("err_cnt",   32'(bus.err_cnt),   32'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
    check_all();
    if (bus.dir_up === 1'b1) up_seen++;
    if (bus.dir_down === 1'b1) down_seen++;
  endtask

  task automatic hold(input int g, input int n);
    bus.gray_in = 4'(g);
    repeat (n) tick();
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cur, r;
    reset = 1'b1;
    bus.gray_in = 4'b0011;
    bus.clr_err = 1'b0;
    model_reset();
    #3;
    check_all();
    tick();
    tick();

    // 1: release, fill, load 0011 -> 2
    reset = 1'b0;
    tick();
    chk("t1_valid_e1", 32'(bus.bin_valid), 32'd0);
    tick();
    tick();
    chk("t1_bin", 32'(bus.bin_out), 32'd2);
    chk("t1_valid", 32'(bus.bin_valid), 32'd1);
    chk("t1_err", 32'(bus.err), 32'd0);

    // 2: count 0..3 up
    hold(0, 4);
    pulse_clr();
    up_seen = 0;
    hold(1, 3);
    hold(3, 3);
    hold(2, 3);
    chk("t2_ups", 32'(up_seen), 32'd3);
    chk("t2_bin", 32'(bus.bin_out), 32'd3);

    // 3: wrap both ways
    hold(8, 4);
    pulse_clr();
    up_seen = 0;
    down_seen = 0;
    hold(0, 3);
    chk("t3_up_wrap", 32'(up_seen), 32'd1);
    chk("t3_bin0", 32'(bus.bin_out), 32'd0);
    hold(8, 3);
    chk("t3_down_wrap", 32'(down_seen), 32'd1);
    chk("t3_bin15", 32'(bus.bin_out), 32'd15);

    // 4: illegal jumps and saturation
    hold(0, 4);
    pulse_clr();
    up_seen = 0;
    down_seen = 0;
    hold(3, 4);
    chk("t4_err", 32'(bus.err), 32'd1);
    chk("t4_cnt1", 32'(bus.err_cnt), 32'd1);
    chk("t4_bin", 32'(bus.bin_out), 32'd2);
    chk("t4_nodir", 32'(up_seen + down_seen), 32'd0);
    for (int i = 0; i < 300; i++) begin
      bus.gray_in = (i % 2 == 0) ? 4'b0000 : 4'b0011;
      tick();
    end
    hold(3, 3);
    chk("t4_sat", 32'(bus.err_cnt), 32'd255);

    // 5: clear collides with a jump, then clear alone
    bus.gray_in = 4'b0000;
    tick();
    tick();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("t5_err", 32'(bus.err), 32'd1);
    chk("t5_cnt", 32'(bus.err_cnt), 32'd1);
    tick();
    pulse_clr();
    chk("t5_clr_err", 32'(bus.err), 32'd0);
    chk("t5_clr_cnt", 32'(bus.err_cnt), 32'd0);

    // 6: reset mid-count at 5
    hold(1, 2);
    hold(3, 2);
    hold(2, 2);
    hold(6, 2);
    hold(7, 4);
    chk("t6_bin5", 32'(bus.bin_out), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("t6_async_bin", 32'(bus.bin_out), 32'd0);
    tick();
    reset = 1'b0;
    up_seen = 0;
    down_seen = 0;
    tick();
    tick();
    chk("t6_valid_low", 32'(bus.bin_valid), 32'd0);
    tick();
    chk("t6_valid", 32'(bus.bin_valid), 32'd1);
    chk("t6_bin", 32'(bus.bin_out), 32'd5);
    chk("t6_nodir", 32'(up_seen + down_seen), 32'd0);
    chk("t6_noerr", 32'(bus.err), 32'd0);

    // random steps, jumps, holds and clears
    cur = 5;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r >= 4 && r <= 5) cur = (cur + 1) % 16;
      else if (r >= 6 && r <= 7) cur = (cur + 15) % 16;
      else if (r >= 8) cur = $urandom_range(0, 15);
      bus.gray_in = 4'(cur ^ (cur >> 1));
      bus.clr_err = ($urandom_range(0, 15) == 0);
      tick();
    end
    bus.clr_err = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
